pipe_trace_buffer: RTL

- Passive trace capture for the PPCPU debug outputs (PC, IF_Inst, WB_Alu).
- Arms on command, triggers when the fetch PC matches a programmed address, then records each new fetch into a circular-free linear buffer until it is full or stopped.
- The bench or a debug host then reads the buffer back through a request/valid port.
- It is the consumer and reader of the pipeline observation interface that the CPU drives.

---
 rtl/pipe_trace_buffer_if.sv | 38 +++
 rtl/pipe_trace_buffer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer_if.sv
// Observation/control/readback bundle between the PPCPU side, debug host and pipe_trace_buffer.
// Rd_WbAlu exists only when TRACE_WB_EN is defined.
interface pipe_trace_buffer_if #(
    parameter int ADDR_W = 4
);
    logic [31:0]     PC;
    logic [31:0]     IF_Inst;
    logic [31:0]     WB_Alu;
    logic [31:0]     Trig_PC;
    logic            Arm;
    logic            Stop;
    logic            Rd_Req;
    logic [63:0]     Rd_Data;
`ifdef TRACE_WB_EN
    logic [31:0]     Rd_WbAlu;
`endif
    logic            Rd_Valid;
    logic            Rd_Err;
    logic [ADDR_W:0] Count;
    logic [1:0]      State;
    logic            Done;

    modport master (
`ifdef TRACE_WB_EN
        input  Rd_WbAlu,
`endif
        output PC, IF_Inst, WB_Alu, Trig_PC, Arm, Stop, Rd_Req,
        input  Rd_Data, Rd_Valid, Rd_Err, Count, State, Done
    );

    modport slave (
`ifdef TRACE_WB_EN
        output Rd_WbAlu,
`endif
        input  PC, IF_Inst, WB_Alu, Trig_PC, Arm, Stop, Rd_Req,
        output Rd_Data, Rd_Valid, Rd_Err, Count, State, Done
    );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Triggered linear trace capture of the PPCPU fetch stream with a 1-cycle request/valid readback.
// Optional macro TRACE_WB_EN stores the write-back ALU value alongside each entry.
module pipe_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               Clock,
    input  logic               Resetn,
    pipe_trace_buffer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

`ifdef TRACE_WB_EN
    localparam int ENTRY_W = 96;
`else
    localparam int ENTRY_W = 64;
`endif
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    state_t              state, state_nxt;
    logic [ADDR_W:0]     count, count_nxt, rd_ptr;
    logic [31:0]         prev_pc;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ENTRY_W-1:0]  wr_entry, rd_entry;
    logic                wr_en, trig_hit, new_fetch, rd_fire;
    logic [63:0]         rd_data;
    logic                rd_valid, rd_err;

`ifdef TRACE_WB_EN
    logic [31:0]         rd_wb;
    assign wr_entry     = {bus.WB_Alu, bus.PC, bus.IF_Inst};
    assign bus.Rd_WbAlu = rd_wb;
`else
    logic                unused_wb;
    assign wr_entry  = {bus.PC, bus.IF_Inst};
    assign unused_wb = ^bus.WB_Alu;
`endif

    assign new_fetch = (bus.PC != prev_pc);
    assign trig_hit  = (bus.PC == bus.Trig_PC);
    assign rd_fire   = bus.Rd_Req && !bus.Arm && (state == DONE);
    assign rd_entry  = mem[rd_ptr[ADDR_W-1:0]];

    // Arm overrides everything; otherwise writes land at entry[count] and the last slot ends capture.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr_en     = 1'b0;
        if (bus.Arm) begin
            state_nxt = ARMED;
            count_nxt = '0;
        end else begin
            case (state)
                ARMED: begin
                    if (trig_hit) begin
                        wr_en     = 1'b1;
                        count_nxt = (ADDR_W+1)'(1);
                        state_nxt = bus.Stop ? DONE : CAPTURE;
                    end else if (bus.Stop) begin
                        state_nxt = DONE;
                    end
                end
                CAPTURE: begin
                    if (new_fetch) begin
                        wr_en     = 1'b1;
                        count_nxt = count + 1'b1;
                        if (count_nxt == FULL) state_nxt = DONE;
                    end
                    if (bus.Stop) state_nxt = DONE;
                end
                default: ;
            endcase
        end
    end

    // Trace RAM keeps its contents across reset; only the bookkeeping is cleared.
    always_ff @(posedge Clock) begin
        if (wr_en) mem[count[ADDR_W-1:0]] <= wr_entry;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            prev_pc  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
`ifdef TRACE_WB_EN
            rd_wb    <= '0;
`endif
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            prev_pc  <= bus.PC;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            if (bus.Arm) begin
                rd_ptr <= '0;
            end else if (rd_fire) begin
                if (rd_ptr < count) begin
                    rd_valid <= 1'b1;
                    rd_data  <= rd_entry[63:0];
                    rd_ptr   <= rd_ptr + 1'b1;
`ifdef TRACE_WB_EN
                    rd_wb    <= rd_entry[95:64];
`endif
                end else begin
                    rd_err <= 1'b1;
                end
            end
        end
    end

    assign bus.Rd_Data  = rd_data;
    assign bus.Rd_Valid = rd_valid;
    assign bus.Rd_Err   = rd_err;
    assign bus.Count    = count;
    assign bus.State    = state;
    assign bus.Done     = (state == DONE);
endmodule
